// File: rtl/ws2812_ctrl.sv
// WS2812 LED chain driver: pulls 24-bit GRB pixels over a valid/ready handshake and
// serialises them MSB first as width-coded pulses, then holds the line low to latch.
module ws2812_ctrl #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned T0H       = 20,
  parameter int unsigned T1H       = 40,
  parameter int unsigned BIT_CYC   = 63,
  parameter int unsigned LATCH_CYC = 15000,
  parameter int unsigned GAP_MAX   = 250
) (
  input  logic        CLK50M,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] PIX_DAT,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  output logic        BUSY,
  output logic        DONE,
  output logic        UNDERRUN,
  output logic        RGB_DAT
);

  localparam int unsigned CNT_MAX = (LATCH_CYC > BIT_CYC) ? LATCH_CYC : BIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned WAIT_W  = $clog2(GAP_MAX + 1);
  localparam int unsigned PIX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CNT_W-1:0]  T0H_END   = CNT_W'(T0H - 1);
  localparam logic [CNT_W-1:0]  T1H_END   = CNT_W'(T1H - 1);
  localparam logic [CNT_W-1:0]  BIT_END   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  LATCH_END = CNT_W'(LATCH_CYC - 1);
  localparam logic [WAIT_W-1:0] GAP_LIM   = WAIT_W'(GAP_MAX);
  localparam logic [PIX_W-1:0]  LAST_PIX  = PIX_W'(NUM_LEDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HIGH,
    LOW,
    LATCH
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WAIT_W-1:0]  wait_q;
  logic [PIX_W-1:0]   pix_q;
  logic [4:0]         bit_q;
  logic [23:0]        shift_q;
  logic [CNT_W-1:0]   high_end;

  // The bit on the wire is always shift_q[23]; the register shifts left per bit.
  always_comb begin
    high_end = shift_q[23] ? T1H_END : T0H_END;
  end

  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wait_q    <= '0;
      pix_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      PIX_READY <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      UNDERRUN  <= 1'b0;
      RGB_DAT   <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // DONE is still high on the completion cycle, so a START there is dropped.
          if (START && !DONE) begin
            state_q   <= LOAD;
            BUSY      <= 1'b1;
            PIX_READY <= 1'b1;
            UNDERRUN  <= 1'b0;
            pix_q     <= '0;
            wait_q    <= '0;
          end
        end
        LOAD: begin
          if (PIX_VALID && PIX_READY) begin
            shift_q   <= PIX_DAT;
            bit_q     <= 5'd23;
            cnt_q     <= '0;
            PIX_READY <= 1'b0;
            RGB_DAT   <= 1'b1;
            state_q   <= HIGH;
          end else if (wait_q != GAP_LIM) begin
            wait_q <= wait_q + 1'b1;
            if (wait_q == GAP_LIM - 1'b1) UNDERRUN <= 1'b1;
          end
        end
        HIGH: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == high_end) begin
            RGB_DAT <= 1'b0;
            state_q <= LOW;
          end
        end
        LOW: begin
          if (cnt_q == BIT_END) begin
            cnt_q <= '0;
            if (bit_q != 5'd0) begin
              bit_q   <= bit_q - 1'b1;
              shift_q <= {shift_q[22:0], 1'b0};
              RGB_DAT <= 1'b1;
              state_q <= HIGH;
            end else if (pix_q != LAST_PIX) begin
              pix_q     <= pix_q + 1'b1;
              wait_q    <= '0;
              PIX_READY <= 1'b1;
              state_q   <= LOAD;
            end else begin
              state_q <= LATCH;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        LATCH: begin
          if (cnt_q == LATCH_END) begin
            cnt_q   <= '0;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_ctrl.sv
// Randomised bench for ws2812_ctrl: a line monitor timestamps every pulse and an
// arithmetic model predicts each rise time, pulse width and the DONE cycle.
module tb_ws2812_ctrl;

  localparam int N     = 3;
  localparam int T0H   = 20;
  localparam int T1H   = 40;
  localparam int BIT   = 63;
  localparam int LATCH = 400;
  localparam int GAP   = 250;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [23:0] pix_dat = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, busy, done, underrun, rgb_dat;

  ws2812_ctrl #(
    .NUM_LEDS (N),
    .T0H      (T0H),
    .T1H      (T1H),
    .BIT_CYC  (BIT),
    .LATCH_CYC(LATCH),
    .GAP_MAX  (GAP)
  ) dut (
    .CLK50M   (clk),
    .RST      (rst),
    .START    (start),
    .PIX_DAT  (pix_dat),
    .PIX_VALID(pix_valid),
    .PIX_READY(pix_ready),
    .BUSY     (busy),
    .DONE     (done),
    .UNDERRUN (underrun),
    .RGB_DAT  (rgb_dat)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor, sampled on the falling edge.
  int   rise_q[$];
  int   hw_q[$];
  int   done_q[$];
  logic done_busy_q[$];
  logic done_pbusy_q[$];
  int   xfer_n = 0;
  int   ur_rise_cyc = -1;
  logic rgb_prev = 1'b0, busy_prev = 1'b0, ur_prev = 1'b0;

  always @(negedge clk) begin
    if (rgb_dat && !rgb_prev) rise_q.push_back(cyc);
    if (!rgb_dat && rgb_prev && rise_q.size() > 0) hw_q.push_back(cyc - rise_q[$]);
    if (done) begin
      done_q.push_back(cyc);
      done_busy_q.push_back(busy);
      done_pbusy_q.push_back(busy_prev);
    end
    if (pix_valid && pix_ready) xfer_n <= xfer_n + 1;
    if (underrun && !ur_prev) ur_rise_cyc <= cyc;
    rgb_prev  <= rgb_dat;
    busy_prev <= busy;
    ur_prev   <= underrun;
  end

  int          n_chk = 0;
  int          n_err = 0;
  logic [23:0] px_a [N];
  int          dly_a [N];
  bit          abort = 1'b0;

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers px_a[i] after dly_a[i] idle LOAD cycles; the line must stay low while waiting.
  task automatic feed(input int budget);
    int t;
    for (int i = 0; i < N && !abort; i++) begin
      pix_valid = 1'b0;
      if (dly_a[i] > 0) begin
        t = 0;
        do begin
          @(negedge clk);
          t++;
        end while (!pix_ready && !abort && t < budget);
        for (int k = 0; k < dly_a[i] && !abort; k++) begin
          n_chk++;
          if (rgb_dat !== 1'b0) begin
            n_err++;
            $display("FAIL load_line_low: pixel %0d wait %0d rgb=%b want 0", i, k, rgb_dat);
          end
          @(negedge clk);
        end
      end
      pix_dat   = px_a[i];
      pix_valid = 1'b1;
      t = 0;
      while (!pix_ready && !abort && t < budget) begin
        @(negedge clk);
        t++;
      end
      if (abort) break;
      n_chk++;
      if (!pix_ready) begin
        n_err++;
        $display("FAIL ready_timeout: pixel %0d ready=%b want 1", i, pix_ready);
        abort = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    pix_valid = 1'b0;
  endtask

  // Mid-frame START, START on the DONE cycle, then START one cycle later.
  task automatic poke(input int rb, input int budget);
    int t = 0;
    while (rise_q.size() < rb + 6 && t < budget) begin
      @(negedge clk);
      t++;
    end
    pulse_start();
    t = 0;
    while (done !== 1'b1 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    pulse_start();
    @(negedge clk);
    n_chk++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_on_done: busy=%b want 0", busy);
    end
    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || pix_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_after_done: busy=%b ready=%b want 1 1", busy, pix_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame from px_a/dly_a and checks the whole line against the model.
  task automatic run_frame(input string name, input bit pokes, output int rb);
    int hb, db, xb, cs, budget, nb, exp_r, exp_w, p, b;
    budget = N * 24 * BIT + N * (GAP + 100) + LATCH + 500;
    nb = 24 * N;
    @(negedge clk);
    rb = rise_q.size();
    hb = hw_q.size();
    db = done_q.size();
    xb = xfer_n;
    cs = cyc;
    abort = 1'b0;
    fork
      begin
        pulse_start();
        feed(budget);
      end
      begin
        int t = 0;
        while (done_q.size() == db && t < budget) begin
          @(negedge clk);
          t++;
        end
        n_chk++;
        if (done_q.size() == db) begin
          n_err++;
          $display("FAIL %s done_timeout: no DONE after %0d cycles, want one", name, budget);
          abort = 1'b1;
        end
      end
      begin
        if (pokes) poke(rb, budget);
      end
    join
    repeat (2) @(negedge clk);
    n_chk++;
    if (xfer_n - xb != N) begin
      n_err++;
      $display("FAIL %s transfers: got %0d want %0d", name, xfer_n - xb, N);
    end
    n_chk++;
    if (rise_q.size() - rb != nb) begin
      n_err++;
      $display("FAIL %s bit_count: got %0d want %0d", name, rise_q.size() - rb, nb);
    end
    exp_r = cs + 2 + dly_a[0];
    for (int idx = 0; idx < nb; idx++) begin
      p = idx / 24;
      b = 23 - (idx % 24);
      if (idx > 0) exp_r += BIT + ((idx % 24 == 0) ? 1 + dly_a[p] : 0);
      exp_w = px_a[p][b] ? T1H : T0H;
      if (rb + idx < rise_q.size()) begin
        n_chk++;
        if (rise_q[rb + idx] != exp_r) begin
          n_err++;
          $display("FAIL %s rise_time: pix %0d bit %0d got %0d want %0d", name, p, b,
                   rise_q[rb + idx] - cs, exp_r - cs);
        end
      end
      if (hb + idx < hw_q.size()) begin
        n_chk++;
        if (hw_q[hb + idx] != exp_w) begin
          n_err++;
          $display("FAIL %s high_width: pix %0d bit %0d got %0d want %0d", name, p, b,
                   hw_q[hb + idx], exp_w);
        end
      end
    end
    if (done_q.size() > db) begin
      n_chk++;
      if (done_q.size() - db != 1) begin
        n_err++;
        $display("FAIL %s done_pulses: got %0d want 1", name, done_q.size() - db);
      end
      n_chk++;
      if (done_q[db] != exp_r + BIT + LATCH) begin
        n_err++;
        $display("FAIL %s done_cycle: got %0d want %0d", name, done_q[db] - cs,
                 exp_r + BIT + LATCH - cs);
      end
      n_chk++;
      if (done_busy_q[db] !== 1'b0 || done_pbusy_q[db] !== 1'b1) begin
        n_err++;
        $display("FAIL %s busy_at_done: got %b->%b want 1->0", name, done_pbusy_q[db],
                 done_busy_q[db]);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({rgb_dat, pix_ready, busy, done, underrun} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b want 00000",
               {rgb_dat, pix_ready, busy, done, underrun});
    end
    start = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_chk++;
    if (pix_ready !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ignores_valid: ready=%b busy=%b want 0 0", pix_ready, busy);
    end
    pix_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    n_chk++;
    if (busy !== 1'b1 || pix_ready !== 1'b1 || rgb_dat !== 1'b0) begin
      n_err++;
      $display("FAIL first_start: busy=%b ready=%b rgb=%b want 1 1 0", busy, pix_ready,
               rgb_dat);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_stream();
    int rb;
    px_a[0] = 24'hA50000;
    for (int i = 1; i < N; i++) px_a[i] = 24'($urandom);
    for (int i = 0; i < N; i++) dly_a[i] = 0;
    run_frame("stream", 1'b0, rb);
    for (int i = 0; i < N; i++) begin
      px_a[i]  = 24'($urandom);
      dly_a[i] = $urandom_range(0, 20);
    end
    run_frame("stream_gaps", 1'b0, rb);
  endtask

  task automatic test_underrun();
    int rb;
    for (int i = 0; i < N; i++) px_a[i] = 24'($urandom);
    dly_a[0] = 0;
    dly_a[1] = 300;
    dly_a[2] = $urandom_range(0, 5);
    run_frame("underrun", 1'b0, rb);
    if (rise_q.size() > rb + 23) begin
      n_chk++;
      if (ur_rise_cyc != rise_q[rb + 23] + BIT + GAP) begin
        n_err++;
        $display("FAIL underrun_time: got %0d want %0d", ur_rise_cyc - rise_q[rb + 23] - BIT,
                 GAP);
      end
    end
    n_chk++;
    if (underrun !== 1'b1) begin
      n_err++;
      $display("FAIL underrun_sticky: got %b want 1", underrun);
    end
    for (int i = 0; i < N; i++) begin
      px_a[i]  = 24'($urandom);
      dly_a[i] = 0;
    end
    run_frame("after_underrun", 1'b0, rb);
    n_chk++;
    if (underrun !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_clear: got %b want 0", underrun);
    end
  endtask

  task automatic test_start_ignored();
    int rb;
    for (int i = 0; i < N; i++) begin
      px_a[i]  = 24'($urandom);
      dly_a[i] = 0;
    end
    run_frame("start_ignored", 1'b1, rb);
  endtask

  task automatic test_reset_midframe();
    int rb, nr, budget;
    budget = N * 24 * BIT + 1000;
    for (int i = 0; i < N; i++) begin
      px_a[i]  = 24'($urandom);
      dly_a[i] = 0;
    end
    @(negedge clk);
    rb = rise_q.size();
    abort = 1'b0;
    fork
      begin
        pulse_start();
        feed(budget);
      end
      begin
        int t = 0;
        while (rise_q.size() < rb + 24 + 14 && t < budget) begin
          @(negedge clk);
          t++;
        end
        n_chk++;
        if (rise_q.size() < rb + 38 || rgb_dat !== 1'b1) begin
          n_err++;
          $display("FAIL reach_pix1_bit10: rises=%0d rgb=%b want 38 1", rise_q.size() - rb,
                   rgb_dat);
        end
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if ({rgb_dat, pix_ready, busy, done, underrun} !== 5'b0) begin
          n_err++;
          $display("FAIL async_reset: got %b want 00000",
                   {rgb_dat, pix_ready, busy, done, underrun});
        end
        abort = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    nr = rise_q.size();
    repeat (300) @(negedge clk);
    n_chk++;
    if (rise_q.size() != nr || busy !== 1'b0) begin
      n_err++;
      $display("FAIL no_resume: new_rises=%0d busy=%b want 0 0", rise_q.size() - nr, busy);
    end
    for (int i = 0; i < N; i++) px_a[i] = 24'($urandom);
    run_frame("fresh_frame", 1'b0, rb);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underrun();
    test_start_ignored();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ws2812_ctrl.md
WS2812_CTRL -- requirements
Module: ws2812_ctrl

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8: pixels per frame, range 1..1023.
REQ-002 SHALL have parameter T0H, default 20: high-phase clock cycles for a 0 bit (0.4 us at 50 MHz).
REQ-003 SHALL have parameter T1H, default 40: high-phase clock cycles for a 1 bit (0.8 us).
REQ-004 SHALL have parameter BIT_CYC, default 63: total clock cycles per bit (1.26 us); T0H < T1H < BIT_CYC.
REQ-005 SHALL have parameter LATCH_CYC, default 15000: low-hold cycles after the frame (300 us).
REQ-006 SHALL have parameter GAP_MAX, default 250: maximum LOAD wait cycles before underrun.
REQ-007 SHALL have port CLK50M, input, 1 bit: sole clock, all logic rising-edge.
REQ-008 SHALL have port RST, input, 1 bit: reset, asynchronous assert, active-high.
REQ-009 SHALL have port START, input, 1 bit: single-cycle frame request.
REQ-010 SHALL have port PIX_DAT, input, 24 bits: pixel in GRB order, G[23:16], R[15:8], B[7:0].
REQ-011 SHALL have port PIX_VALID, input, 1 bit: PIX_DAT valid.
REQ-012 SHALL have port PIX_READY, output, 1 bit: the controller accepts a pixel.
REQ-013 SHALL have port BUSY, output, 1 bit: high while the state is not IDLE.
REQ-014 SHALL have port DONE, output, 1 bit: one-cycle pulse at frame completion.
REQ-015 SHALL have port UNDERRUN, output, 1 bit: sticky flag for pixel starvation.
REQ-016 SHALL have port RGB_DAT, output, 1 bit: registered serial line to the LED chain.

Function
REQ-017 SHALL implement the states IDLE, LOAD, HIGH, LOW and LATCH.
REQ-018 In IDLE, SHALL go to LOAD on the cycle after START=1; SHALL also clear UNDERRUN and set the pixel counter to 0.
REQ-019 In IDLE, SHALL ignore PIX_VALID; PIX_READY=0.
REQ-020 In LOAD, SHALL hold PIX_READY=1; a transfer occurs on the cycle where PIX_VALID&PIX_READY; on transfer, SHALL capture PIX_DAT into the shift register, set bit index to 23 and go to HIGH.
REQ-021 In LOAD, SHALL drive RGB_DAT=0; the wait counter SHALL increment each non-transfer cycle.
REQ-022 When the wait counter reaches GAP_MAX, SHALL set UNDERRUN=1 and remain in LOAD; a late pixel is still accepted.
REQ-023 On the cycle after transfer, SHALL drive RGB_DAT=1: capture-to-line latency is exactly 1 cycle.
REQ-024 In HIGH, SHALL hold RGB_DAT=1 for T1H cycles if the current bit is 1, or T0H cycles if it is 0; then go to LOW.
REQ-025 In LOW, SHALL hold RGB_DAT=0 so that HIGH+LOW equals BIT_CYC cycles.
REQ-026 Bits SHALL be sent MSB first (bit 23 first).
REQ-027 At the end of LOW, if bits remain, SHALL decrement the bit index and go to HIGH, with no extra cycle between bits.
REQ-028 At the end of LOW after bit 0, if the pixel count is below NUM_LEDS-1, SHALL increment the count and go to LOAD.
REQ-029 The inter-pixel low time SHALL be BIT_CYC-T?H+1+wait cycles; with PIX_VALID held high this is 1 cycle over nominal, within WS2812 tolerance.
REQ-030 At the end of LOW after bit 0 of pixel NUM_LEDS-1, SHALL go to LATCH.
REQ-031 In LATCH, SHALL hold RGB_DAT=0 for LATCH_CYC cycles, then pulse DONE=1 for exactly one cycle and go to IDLE with BUSY=0 on that same cycle.
REQ-032 START while BUSY=1 SHALL be ignored; it is not queued.
REQ-033 START on the same cycle as DONE SHALL be ignored; START on the next cycle SHALL be accepted.
REQ-034 Counters SHALL be sized by clog2 of their maximum value; no counter may wrap during normal operation.

Reset
REQ-035 While RST=1, SHALL force: state=IDLE, RGB_DAT=0, PIX_READY=0, BUSY=0, DONE=0, UNDERRUN=0, all counters 0, shift register 0.
REQ-036 RST asserted mid-frame SHALL take effect asynchronously; RGB_DAT SHALL drop to 0 the same instant.
REQ-037 No partial frame SHALL resume after reset release; a new START is required.
REQ-038 The first START SHALL be honoured on the first clock edge after RST deasserts.

Verification
REQ-039 Default parameters, NUM_LEDS=1, START then PIX_DAT=24'hA50000 with PIX_VALID held -> 24 bits observed with high widths 40,20,40,20,20,40,20,40 then sixteen of 20; every bit period 63 cycles; then 15000 low cycles, DONE pulse, BUSY falls.
REQ-040 NUM_LEDS=2, PIX_VALID always 1 -> two PIX_READY transfers; low gap between pixels equals 63-TxH+1; total frame 2*24*63+1+15000 cycles ±1 from START.
REQ-041 PIX_VALID withheld 300 cycles in LOAD -> UNDERRUN=1 at wait cycle 250; RGB_DAT=0 throughout; a late pixel is sent correctly; UNDERRUN stays 1 until the next START.
REQ-042 START pulsed during HIGH of bit 5 and again on the DONE cycle -> both ignored; output bit stream unchanged; BUSY=0 after DONE.
REQ-043 RST pulsed during HIGH of bit 10 of pixel 1 -> RGB_DAT=0 immediately; all outputs at reset values; a later START sends a complete fresh frame starting at pixel 0.
